// File: rtl/gf_muls_2_masked_pipe_if.sv
// Operand/result bus for gf_muls_2_masked_pipe: valid/ready handshake on both sides.
// With GF_MULS_REFRESH_EN defined, the bus also carries rnd (fresh mask) and q_mask.
interface gf_muls_2_masked_pipe_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3*LANES-1:0]   a;
  logic [3*LANES-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*LANES-1:0]   q;
  logic                 err;
`ifdef GF_MULS_REFRESH_EN
  logic [2*LANES-1:0]   rnd;
  logic [2*LANES-1:0]   q_mask;

  modport master (
    output in_valid, a, b, out_ready, rnd,
    input  in_ready, out_valid, q, err, q_mask
  );
  modport slave (
    input  in_valid, a, b, out_ready, rnd,
    output in_ready, out_valid, q, err, q_mask
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, err
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, err
  );
`endif
endinterface

// File: rtl/gf_muls_2_masked_pipe.sv
// Two-stage pipelined GF(2^2) multiplier (normal basis [W^2, W]) over LANES lanes with a
// sticky operand-consistency flag. Optional output refresh is enabled by GF_MULS_REFRESH_EN.

// Per-lane datapath: AND layer feeding stage 1, XOR layer feeding stage 2.
module gf_muls_2_lane (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic [2:0] t_i,
  output logic [2:0] t_o,
  output logic [1:0] pq_o,
  output logic       bad_o
);
  assign t_o   = a_i & b_i;
  // XOR layer reads only registered AND terms so no glitch crosses between layers.
  assign pq_o  = {t_i[1] ^ t_i[2], t_i[0] ^ t_i[2]};
  assign bad_o = (a_i[2] != (a_i[1] ^ a_i[0])) | (b_i[2] != (b_i[1] ^ b_i[0]));
endmodule

module gf_muls_2_masked_pipe #(
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gf_muls_2_masked_pipe_if.slave  bus
);
  localparam int STAGES = 2;

  logic [STAGES:1]               vld_q, vld_d;
  logic                          err_q, err_d;
  logic                          adv2, in_ready, acc;

  logic [LANES-1:0][2:0]         a_l, b_l;
  logic [LANES-1:0][2:0]         t_new;
  logic [LANES-1:0][2:0]         t_q, t_d;
  logic [LANES-1:0][1:0]         pq;
  logic [LANES-1:0][1:0]         s2_q, s2_d;
  logic [LANES-1:0]              bad;
  logic [LANES-1:0][1:0]         mask_in;

`ifdef GF_MULS_REFRESH_EN
  logic [LANES-1:0][1:0]         rnd1_q, rnd1_d;
  logic [LANES-1:0][1:0]         msk2_q, msk2_d;
`endif

  assign a_l = bus.a;
  assign b_l = bus.b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf_muls_2_lane u_lane (
      .a_i   (a_l[k]),
      .b_i   (b_l[k]),
      .t_i   (t_q[k]),
      .t_o   (t_new[k]),
      .pq_o  (pq[k]),
      .bad_o (bad[k])
    );
  end

  // Handshake: in_ready must not depend on in_valid.
  always_comb begin
    adv2     = vld_q[1] & (~vld_q[2] | bus.out_ready);
    in_ready = ~vld_q[1] | adv2;
    acc      = bus.in_valid & in_ready;
    vld_d[1] = acc | (vld_q[1] & ~adv2);
    vld_d[2] = adv2 | (vld_q[2] & ~bus.out_ready);
    err_d    = err_q | (acc & (|bad));
  end

`ifdef GF_MULS_REFRESH_EN
  assign mask_in = rnd1_q;
`else
  assign mask_in = '0;
`endif

  always_comb begin
    t_d  = t_q;
    s2_d = s2_q;
    if (acc)  t_d  = t_new;
    if (adv2) s2_d = pq ^ mask_in;
  end

`ifdef GF_MULS_REFRESH_EN
  always_comb begin
    rnd1_d = rnd1_q;
    msk2_d = msk2_q;
    if (acc)  rnd1_d = bus.rnd;
    if (adv2) msk2_d = rnd1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd1_q <= '0;
      msk2_q <= '0;
    end else begin
      rnd1_q <= rnd1_d;
      msk2_q <= msk2_d;
    end
  end

  assign bus.q_mask = msk2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= 1'b0;
      t_q   <= '0;
      s2_q  <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      t_q   <= t_d;
      s2_q  <= s2_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q[2];
  assign bus.q         = s2_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_gf_muls_2_masked_pipe.sv
// Directed self-checking bench for gf_muls_2_masked_pipe (LANES=4; single-lane vectors use lane 0).
module tb_gf_muls_2_masked_pipe;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  gf_muls_2_masked_pipe_if #(.LANES(LANES)) bus ();

  gf_muls_2_masked_pipe #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product per lane: t2=a2&b2, t1=a1&b1, t0=a0&b0 -> {t1^t2, t0^t2}.
  function automatic logic [2*LANES-1:0] model(input logic [3*LANES-1:0] a,
                                               input logic [3*LANES-1:0] b);
    logic [2*LANES-1:0] r;
    logic [2:0] x, y;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      x = a[3*k +: 3];
      y = b[3*k +: 3];
      r[2*k +: 2] = {(x[1] & y[1]) ^ (x[2] & y[2]), (x[0] & y[0]) ^ (x[2] & y[2])};
    end
    return r;
  endfunction

  function automatic logic [3*LANES-1:0] rand_consistent();
    logic [3*LANES-1:0] v;
    logic hi, lo;
    for (int k = 0; k < LANES; k++) begin
      hi = 1'($urandom_range(1));
      lo = 1'($urandom_range(1));
      v[3*k +: 3] = {hi ^ lo, hi, lo};
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.q !== '0) $display("FAIL reset_q got=%h exp=0", bus.q); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [2:0] va [4];
    logic [2:0] vb [4];
    logic [1:0] ve [4];
    va[0] = 3'b110; vb[0] = 3'b110; ve[0] = 2'b01;
    va[1] = 3'b101; vb[1] = 3'b101; ve[1] = 2'b10;
    va[2] = 3'b011; vb[2] = 3'b011; ve[2] = 2'b11;
    va[3] = 3'b000; vb[3] = 3'b101; ve[3] = 2'b00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a = {9'b0, va[i]};
      bus.b = {9'b0, vb[i]};
      bus.in_valid = 1'b1;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL basic%0d_in_ready got=%b exp=1", i, bus.in_ready); else n_pass++;
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL basic%0d_early_valid got=%b exp=0", i, bus.out_valid); else n_pass++;
      tick();
      n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL basic%0d_out_valid got=%b exp=1", i, bus.out_valid); else n_pass++;
      n_chk++; if (bus.q[1:0] !== ve[i]) $display("FAIL basic%0d_q got=%b exp=%b", i, bus.q[1:0], ve[i]); else n_pass++;
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL basic%0d_drain got=%b exp=0", i, bus.out_valid); else n_pass++;
    end
  endtask

  task automatic test_streaming();
    logic [3*LANES-1:0] sa [16];
    logic [3*LANES-1:0] sb [16];
    int sent = 0, rcv = 0, first = -1, last = -1, ir_bad = 0;
    for (int i = 0; i < 16; i++) begin
      sa[i] = rand_consistent();
      sb[i] = rand_consistent();
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus.in_valid = (sent < 16);
      if (sent < 16) begin
        bus.a = sa[sent];
        bus.b = sb[sent];
      end
      #1;
      if (bus.in_valid && bus.in_ready !== 1'b1) ir_bad++;
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_chk++;
        if (rcv >= 16) $display("FAIL stream_extra beat got=%h exp=none", bus.q);
        else if (bus.q !== model(sa[rcv], sb[rcv]))
          $display("FAIL stream_q%0d got=%h exp=%h", rcv, bus.q, model(sa[rcv], sb[rcv]));
        else n_pass++;
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    n_chk++; if (ir_bad != 0) $display("FAIL stream_in_ready low_cycles=%0d exp=0", ir_bad); else n_pass++;
    n_chk++; if (rcv != 16) $display("FAIL stream_count got=%0d exp=16", rcv); else n_pass++;
    n_chk++; if (last - first != 15) $display("FAIL stream_rate span=%0d exp=15", last - first); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL stream_err got=%b exp=0", bus.err); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3*LANES-1:0] ba [3];
    logic [3*LANES-1:0] bb [3];
    logic [2*LANES-1:0] held;
    int sent = 0, rcv = 0;
    for (int i = 0; i < 3; i++) begin
      ba[i] = rand_consistent();
      bb[i] = rand_consistent();
    end
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      bus.in_valid = (sent < 3);
      if (sent < 3) begin
        bus.a = ba[sent];
        bus.b = bb[sent];
      end
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    #1;
    n_chk++; if (sent != 2) $display("FAIL bp_accepted got=%0d exp=2", sent); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); else n_pass++;
    n_chk++; if (bus.q !== model(ba[0], bb[0])) $display("FAIL bp_head got=%h exp=%h", bus.q, model(ba[0], bb[0])); else n_pass++;
    held = model(ba[0], bb[0]);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.q !== held)
        $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.q, held);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.in_valid = (sent < 3);
      if (sent < 3) begin
        bus.a = ba[sent];
        bus.b = bb[sent];
      end
      #1;
      if (bus.out_valid === 1'b1) begin
        n_chk++;
        if (rcv >= 3) $display("FAIL bp_dup got=%h exp=none", bus.q);
        else if (bus.q !== model(ba[rcv], bb[rcv]))
          $display("FAIL bp_drain%0d got=%h exp=%h", rcv, bus.q, model(ba[rcv], bb[rcv]));
        else n_pass++;
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    n_chk++; if (rcv != 3) $display("FAIL bp_count got=%0d exp=3", rcv); else n_pass++;
  endtask

  task automatic test_consistency();
    bus.out_ready = 1'b1;
    bus.a = {3'b110, 3'b111, 3'b110, 3'b110};
    bus.b = {3'b110, 3'b110, 3'b110, 3'b110};
    bus.in_valid = 1'b1;
    #1;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL cons_pre_err got=%b exp=0", bus.err); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_chk++; if (bus.err !== 1'b1) $display("FAIL cons_err_set got=%b exp=1", bus.err); else n_pass++;
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.q !== 8'b01010101)
      $display("FAIL cons_q got=%b/%b exp=1/01010101", bus.out_valid, bus.q);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = (i < 10);
      bus.a = rand_consistent();
      bus.b = rand_consistent();
      tick();
      n_chk++; if (bus.err !== 1'b1) $display("FAIL cons_sticky%0d got=%b exp=1", i, bus.err); else n_pass++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = {4{3'b011}};
    bus.b = {4{3'b011}};
    tick();
    bus.a = {4{3'b101}};
    bus.b = {4{3'b101}};
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL rmid_full got=%b/%b exp=1/0", bus.out_valid, bus.in_ready);
    else n_pass++;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.q !== '0) $display("FAIL rmid_q got=%h exp=0", bus.q); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL rmid_err got=%b exp=0", bus.err); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_ghost%0d got=%b exp=0", i, bus.out_valid); else n_pass++;
    end
  endtask

`ifdef GF_MULS_REFRESH_EN
  task automatic test_refresh();
    bus.out_ready = 1'b1;
    bus.a = {9'b0, 3'b110};
    bus.b = {9'b0, 3'b110};
    bus.rnd = {6'b0, 2'b11};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.rnd = '0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL refresh_valid got=%b exp=1", bus.out_valid); else n_pass++;
    n_chk++; if (bus.q[1:0] !== 2'b10) $display("FAIL refresh_q got=%b exp=10", bus.q[1:0]); else n_pass++;
    n_chk++; if (bus.q_mask[1:0] !== 2'b11) $display("FAIL refresh_mask got=%b exp=11", bus.q_mask[1:0]); else n_pass++;
    n_chk++;
    if ((bus.q[1:0] ^ bus.q_mask[1:0]) !== 2'b01)
      $display("FAIL refresh_unmask got=%b exp=01", bus.q[1:0] ^ bus.q_mask[1:0]);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef GF_MULS_REFRESH_EN
    bus.rnd = '0;
`endif
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_consistency();
    test_reset_mid();
`ifdef GF_MULS_REFRESH_EN
    test_refresh();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
